// File: rtl/sipo_ctrl_pkg.sv
// Shared types and sizing helpers for the SIPO frame sequencer.
package sipo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Word counter must be able to hold FRAME_WORDS itself, not just FRAME_WORDS-1.
    function automatic int cnt_w(input int frame_words);
        return $clog2(frame_words + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_cnt.sv
// Bit/word position counters for one frame; flags the last bit of a word and of the frame.
module sipo_frame_cnt
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int FRAME_WORDS = 4,
    parameter int CNT_W       = cnt_w(FRAME_WORDS)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic word_end,
    output logic frame_end
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] word_cnt;

    assign word_end  = inc && (bit_cnt == BIT_W'(WIDTH - 1));
    assign frame_end = word_end && (word_cnt == CNT_W'(FRAME_WORDS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (inc) begin
            if (word_end) begin
                bit_cnt  <= '0;
                word_cnt <= word_cnt + 1'b1;
            end else begin
                bit_cnt  <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for an external SIPO: gates shifting, clears at frame start,
// and captures completed words into a valid/ready output register.
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic [WIDTH-1:0] sipo_q,
    output logic             sipo_shift_en,
    output logic             sipo_clear,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             word_last,
    output logic             frame_done,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = cnt_w(FRAME_WORDS);

    state_e state, state_nxt;
    logic   cap_pend, cap_last;
    logic   word_end, frame_end;
    logic   out_free;

    sipo_frame_cnt #(
        .WIDTH       (WIDTH),
        .FRAME_WORDS (FRAME_WORDS),
        .CNT_W       (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clear     (frame_start),
        .inc       (sipo_shift_en),
        .word_end  (word_end),
        .frame_end (frame_end)
    );

    always_comb begin
        state_nxt     = state;
        sipo_clear    = frame_start;
        sipo_shift_en = (state == SHIFT) && bit_valid && !frame_start;
        case (state)
            IDLE:    if (frame_start) state_nxt = SHIFT;
            SHIFT:   if (!frame_start && frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_free = !word_valid || word_ready;
    assign busy     = (state != IDLE) || cap_pend || word_valid;

    // Capture happens one cycle after the last bit shifts in, so sipo_q is
    // already complete; the SIPO may take the next word's first bit meanwhile.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cap_pend   <= 1'b0;
            cap_last   <= 1'b0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cap_pend   <= word_end;
            if (word_end)
                cap_last <= frame_end;
            frame_done <= word_valid && word_ready && word_last;

            if (cap_pend && out_free) begin
                word_data  <= sipo_q;
                word_valid <= 1'b1;
                word_last  <= cap_last;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            if (cap_pend && !out_free)
                overrun <= 1'b1;
            else if (frame_start)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench: behavioural SIPO + sipo_frame_ctrl, scoreboarded word output.
module tb_sipo_frame_ctrl;

    localparam int W  = 4;
    localparam int FW = 2;

    logic         clk = 1'b0;
    logic         reset, frame_start, bit_valid, serial_in, word_ready;
    logic [W-1:0] sipo_q, word_data;
    logic         sipo_shift_en, sipo_clear, word_valid, word_last;
    logic         frame_done, overrun, busy;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    // Reference SIPO: first bit ends in the MSB.
    always_ff @(posedge clk) begin
        if (reset || sipo_clear) sipo_q <= '0;
        else if (sipo_shift_en)  sipo_q <= {sipo_q[W-2:0], serial_in};
    end

    sipo_frame_ctrl #(.WIDTH(W), .FRAME_WORDS(FW)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .bit_valid     (bit_valid),
        .sipo_q        (sipo_q),
        .sipo_shift_en (sipo_shift_en),
        .sipo_clear    (sipo_clear),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_last     (word_last),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (word_valid && word_ready) begin
                if (sb.size() == 0) chk("unexpected_word", {27'd0, word_last, word_data}, 32'hdead);
                else begin
                    logic [W:0] e;
                    e = sb.pop_front();
                    chk("word_data", word_data, e[W-1:0]);
                    chk("word_last", word_last, e[W]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        bit_valid = 1'b1; serial_in = b; tick();
        if (gap) begin
            bit_valid = 1'b0; serial_in = ~b; tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic last, input bit push, input bit gap);
        if (push) sb.push_back({last, w});
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (sb.size() != 0 || word_valid); i++) tick();
        chk(tag, sb.size(), 0);
        tick(); tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        sb.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_shift_en"}, sipo_shift_en, 0);
        chk({tag, "_word_data"}, word_data, 0);
        chk({tag, "_word_valid"}, word_valid, 0);
        chk({tag, "_word_last"}, word_last, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic full_frame(input string tag, input bit gap);
        int d0;
        d0 = done_cnt;
        word_ready = 1'b1;
        pulse_start();
        send_word(4'b1010, 1'b0, 1'b1, gap);
        send_word(4'b0110, 1'b1, 1'b1, gap);
        drain({tag, "_drain"});
        chk({tag, "_frame_done"}, done_cnt - d0, 1);
        @(negedge clk);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0; word_ready = 1'b0;

        // 1: reset held with bit_valid asserted
        bit_valid = 1'b1; serial_in = 1'b1;
        tick(); tick();
        check_idle_outputs("reset");
        bit_valid = 1'b0;
        reset = 1'b0; tick();

        // 2: back-to-back frame, consumer always ready
        full_frame("b2b", 1'b0);

        // 3: consumer stalled -> second word dropped
        word_ready = 1'b0;
        pulse_start();
        send_word(4'b1010, 1'b0, 1'b0, 1'b0);
        send_word(4'b0110, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        @(negedge clk);
        chk("stall_valid", word_valid, 1);
        chk("stall_data", word_data, 4'b1010);
        chk("stall_last", word_last, 0);
        chk("stall_overrun", overrun, 1);
        pulse_start();
        @(negedge clk);
        chk("restart_overrun", overrun, 0);
        chk("restart_hold", word_data, 4'b1010);
        do_reset();

        // 4: bit_valid gapped every other cycle
        full_frame("gap", 1'b1);

        // 5: restart discards partial word
        word_ready = 1'b1;
        pulse_start();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        pulse_start();
        send_word(4'b1100, 1'b0, 1'b1, 1'b0);
        drain("restart_drain");
        do_reset();

        // 6: bits in IDLE do nothing; reset mid-frame; fresh frame afterwards
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; serial_in = 1'b1;
            @(negedge clk);
            chk("idle_shift_en", sipo_shift_en, 0);
            chk("idle_sipo_q", sipo_q, 0);
            tick();
        end
        bit_valid = 1'b0;
        pulse_start();
        send_word(4'b1010, 1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        drain("mid_drain");
        do_reset();
        check_idle_outputs("midreset");
        full_frame("fresh", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
